seq_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector. Successor to the fixed 3-bit framed detector FSM.
- Adds programmable pattern length, runtime pattern and don't-care mask, framed or sliding (overlapping) mode, input-valid qualification, and a saturating match counter.
- Sits after a serial data source. Drives match pulses and statistics to control logic.

---
 rtl/seq_detector_param.sv | 108 ++++++++++
 tb/tb_seq_detector_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: programmable LEN-bit pattern with a don't-care mask,
// framed or sliding matching, input-valid qualification and a saturating match counter.
module seq_detector_param #(
    parameter int LEN   = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             mode,
    input  logic [LEN-1:0]   pattern,
    input  logic [LEN-1:0]   care,
    input  logic             clr_cnt,
    output logic             y,
    output logic             frame_end,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int PW = $clog2(LEN);
    localparam logic [PW-1:0] LAST = PW'(LEN - 1);

    // FULL means the sliding window already holds LEN-1 history bits.
    typedef enum logic {FILL, FULL} state_e;

    state_e           state_q, state_d;
    logic [LEN-2:0]   sh_q, sh_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [PW-1:0]    fill_q, fill_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [LEN-1:0]   win;
    logic             match;
    logic             resync;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        sh_d      = sh_q;
        pos_d     = pos_q;
        fill_d    = fill_q;
        mode_d    = mode_q;
        y         = 1'b0;
        frame_end = 1'b0;

        win    = {sh_q, x};
        match  = ((win ^ pattern) & care) == '0;
        resync = x_valid && (mode != mode_q);

        if (x_valid) begin
            sh_d = win[LEN-2:0];
            if (resync) begin
                // The switching bit becomes bit 0 of a fresh frame/window and never matches.
                pos_d  = PW'(1);
                fill_d = PW'(1);
                mode_d = mode;
            end else if (!mode_q) begin
                frame_end = (pos_q == LAST);
                y         = match && frame_end;
                pos_d     = frame_end ? '0 : pos_q + PW'(1);
                fill_d    = '0;
            end else begin
                y     = match && (state_q == FULL);
                pos_d = '0;
                if (state_q == FILL) fill_d = fill_q + PW'(1);
            end
        end

        state_d = (fill_d == LAST) ? FULL : FILL;

        if (reset) begin
            y         = 1'b0;
            frame_end = 1'b0;
        end

        cnt_d = cnt_q;
        if (clr_cnt)           cnt_d = '0;
        else if (y && !sat_q)  cnt_d = cnt_q + CNT_W'(1);
        sat_d = &cnt_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            sh_q    <= '0;
            pos_q   <= '0;
            fill_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            pos_q   <= pos_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: spec-derived vector tables plus a history-queue reference model
// run against three instances (LEN=3/CNT_W=8, LEN=3/CNT_W=2, LEN=5/CNT_W=4).
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic reset, x, x_valid, mode, clr_cnt;
    logic [2:0] p3, c3;
    logic [4:0] p5, c5;

    logic       y3, fe3, sat3;
    logic [7:0] cnt3;
    logic       ys, fes, sats;
    logic [1:0] cnts;
    logic       y5, fe5, sat5;
    logic [3:0] cnt5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.LEN(3), .CNT_W(8)) dut3 (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .mode(mode),
        .pattern(p3), .care(c3), .clr_cnt(clr_cnt),
        .y(y3), .frame_end(fe3), .match_cnt(cnt3), .cnt_sat(sat3));

    seq_detector_param #(.LEN(3), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .mode(mode),
        .pattern(p3), .care(c3), .clr_cnt(clr_cnt),
        .y(ys), .frame_end(fes), .match_cnt(cnts), .cnt_sat(sats));

    seq_detector_param #(.LEN(5), .CNT_W(4)) dut5 (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .mode(mode),
        .pattern(p5), .care(c5), .clr_cnt(clr_cnt),
        .y(y5), .frame_end(fe5), .match_cnt(cnt5), .cnt_sat(sat5));

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: valid bits since reset, and the length/mode of the current segment.
    bit hist[$];
    int seg_n;
    bit seg_mode;
    int mcnt[3];
    int lens[3] = '{3, 3, 5};
    int maxc[3] = '{255, 3, 15};
    bit ey[3], efe[3];

    function automatic bit model_match(int len, logic [15:0] pat, logic [15:0] cm, bit xb);
        if (hist.size() < len - 1) return 1'b0;
        for (int i = 0; i < len; i++) begin
            bit w = (i == 0) ? xb : hist[hist.size() - i];
            if (cm[i] && (w != pat[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_check();
        bit rs = x_valid && (mode != seg_mode);
        logic ay[3], afe[3], asat[3];
        int acnt[3];
        ay   = '{y3, ys, y5};
        afe  = '{fe3, fes, fe5};
        asat = '{sat3, sats, sat5};
        acnt = '{int'(cnt3), int'(cnts), int'(cnt5)};
        for (int k = 0; k < 3; k++) begin
            logic [15:0] pat = (k == 2) ? {11'b0, p5} : {13'b0, p3};
            logic [15:0] cm  = (k == 2) ? {11'b0, c5} : {13'b0, c3};
            int nn = seg_n + 1;
            ey[k]  = 1'b0;
            efe[k] = 1'b0;
            if (x_valid && !reset && !rs) begin
                if (!seg_mode) begin
                    efe[k] = (nn % lens[k]) == 0;
                    ey[k]  = efe[k] && model_match(lens[k], pat, cm, x);
                end else begin
                    ey[k] = (nn >= lens[k]) && model_match(lens[k], pat, cm, x);
                end
            end
            check($sformatf("model y[%0d]", k), 32'(ay[k]), 32'(ey[k]));
            check($sformatf("model frame_end[%0d]", k), 32'(afe[k]), 32'(efe[k]));
            check($sformatf("model match_cnt[%0d]", k), acnt[k], mcnt[k]);
            check($sformatf("model cnt_sat[%0d]", k), 32'(asat[k]), 32'(mcnt[k] == maxc[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (x_valid) begin
            if (mode != seg_mode) begin
                seg_mode = mode;
                seg_n    = 1;
            end else begin
                seg_n++;
            end
            hist.push_back(x);
            if (hist.size() > 32) void'(hist.pop_front());
        end
        for (int k = 0; k < 3; k++) begin
            if (clr_cnt) mcnt[k] = 0;
            else if (ey[k] && mcnt[k] < maxc[k]) mcnt[k]++;
        end
        @(negedge clk);
    endtask

    task automatic step();
        #1;
        model_check();
        tick();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        x       = 1'b1;
        x_valid = 1'b1;
        mode    = 1'($urandom_range(0, 1));
        #1;
        check("reset y3", 32'(y3), 0);
        check("reset fe3", 32'(fe3), 0);
        check("reset y5", 32'(y5), 0);
        check("reset cnt3", 32'(cnt3), 0);
        check("reset cnts", 32'(cnts), 0);
        check("reset sats", 32'(sats), 0);
        @(posedge clk);
        @(negedge clk);
        check("reset held y3", 32'(y3), 0);
        reset   = 1'b0;
        x_valid = 1'b0;
        mode    = 1'b0;
        clr_cnt = 1'b0;
        hist.delete();
        seg_n    = 0;
        seg_mode = 1'b0;
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
    endtask

    typedef struct {
        bit       x;
        bit       v;
        bit       md;
        bit       clr;
        logic [2:0] pat;
        logic [2:0] care;
        bit       ey;
        bit       efe;
    } vec_t;

    vec_t vq[$];

    task automatic add(bit xb, bit v, bit md, bit clr, logic [2:0] pat, logic [2:0] cm, bit e_y, bit e_fe);
        vec_t t;
        t.x = xb; t.v = v; t.md = md; t.clr = clr; t.pat = pat; t.care = cm; t.ey = e_y; t.efe = e_fe;
        vq.push_back(t);
    endtask

    task automatic run_vectors(string tag);
        foreach (vq[i]) begin
            x       = vq[i].x;
            x_valid = vq[i].v;
            mode    = vq[i].md;
            clr_cnt = vq[i].clr;
            p3      = vq[i].pat;
            c3      = vq[i].care;
            #1;
            check($sformatf("%s[%0d] y", tag, i), 32'(y3), 32'(vq[i].ey));
            check($sformatf("%s[%0d] frame_end", tag, i), 32'(fe3), 32'(vq[i].efe));
            model_check();
            tick();
        end
        vq.delete();
    endtask

    initial begin
        reset = 1'b1; x = 1'b0; x_valid = 1'b0; mode = 1'b0; clr_cnt = 1'b0;
        p3 = 3'b001; c3 = 3'b111; p5 = 5'b10110; c5 = 5'b11111;
        seg_n = 0; seg_mode = 1'b0;
        @(negedge clk);
        do_reset();

        // Framed detection: 001 011 000 001
        add(0,1,0,0,3'b001,3'b111,0,0); add(0,1,0,0,3'b001,3'b111,0,0); add(1,1,0,0,3'b001,3'b111,1,1);
        add(0,1,0,0,3'b001,3'b111,0,0); add(1,1,0,0,3'b001,3'b111,0,0); add(1,1,0,0,3'b001,3'b111,0,1);
        add(0,1,0,0,3'b001,3'b111,0,0); add(0,1,0,0,3'b001,3'b111,0,0); add(0,1,0,0,3'b001,3'b111,0,1);
        add(0,1,0,0,3'b001,3'b111,0,0); add(0,1,0,0,3'b001,3'b111,0,0); add(1,1,0,0,3'b001,3'b111,1,1);
        run_vectors("framed");
        check("framed match_cnt", 32'(cnt3), 2);

        // Sliding 1,0,1,0,1 with pattern 101, then switch back to framed
        do_reset();
        add(1,1,1,0,3'b101,3'b111,0,0); add(0,1,1,0,3'b101,3'b111,0,0); add(1,1,1,0,3'b101,3'b111,1,0);
        add(0,1,1,0,3'b101,3'b111,0,0); add(1,1,1,0,3'b101,3'b111,1,0);
        add(0,1,0,0,3'b101,3'b111,0,0); add(0,1,0,0,3'b101,3'b111,0,0);
        run_vectors("sliding");
        check("sliding match_cnt", 32'(cnt3), 2);
        x = 1'b1; x_valid = 1'b1; mode = 1'b0; p3 = 3'b101;
        #1;
        check("switch frame 001 vs 101 y", 32'(y3), 0);
        check("switch frame frame_end", 32'(fe3), 1);
        model_check();
        p3 = 3'b001;
        #1;
        check("pattern change same-cycle y", 32'(y3), 1);
        model_check();
        tick();
        check("switch match_cnt", 32'(cnt3), 3);

        // Valid gaps in framed mode
        do_reset();
        add(0,1,0,0,3'b001,3'b111,0,0); add(1,0,0,0,3'b001,3'b111,0,0); add(1,0,0,0,3'b001,3'b111,0,0);
        add(0,1,0,0,3'b001,3'b111,0,0); add(1,1,0,0,3'b001,3'b111,1,1);
        run_vectors("gaps");

        // Care mask 101
        do_reset();
        add(0,1,0,0,3'b001,3'b101,0,0); add(1,1,0,0,3'b001,3'b101,0,0); add(1,1,0,0,3'b001,3'b101,1,1);
        add(1,1,0,0,3'b001,3'b101,0,0); add(1,1,0,0,3'b001,3'b101,0,0); add(1,1,0,0,3'b001,3'b101,0,1);
        run_vectors("care");

        // Counter saturation and clear-over-increment priority
        do_reset();
        for (int f = 0; f < 5; f++) begin
            add(0,1,0,0,3'b001,3'b111,0,0); add(0,1,0,0,3'b001,3'b111,0,0); add(1,1,0,0,3'b001,3'b111,1,1);
        end
        run_vectors("sat");
        check("sat cnts", 32'(cnts), 3);
        check("sat cnt_sat", 32'(sats), 1);
        check("sat wide cnt", 32'(cnt3), 5);
        check("sat wide cnt_sat", 32'(sat3), 0);
        add(0,1,0,0,3'b001,3'b111,0,0); add(0,1,0,0,3'b001,3'b111,0,0); add(1,1,0,1,3'b001,3'b111,1,1);
        run_vectors("clr");
        check("clr cnts", 32'(cnts), 0);
        check("clr cnt_sat", 32'(sats), 0);
        check("clr wide cnt", 32'(cnt3), 0);

        // Reset in the middle of a frame
        do_reset();
        add(0,1,0,0,3'b001,3'b111,0,0); add(0,1,0,0,3'b001,3'b111,0,0);
        run_vectors("pre_rst");
        do_reset();
        add(1,1,0,0,3'b001,3'b111,0,0); add(0,1,0,0,3'b001,3'b111,0,0); add(0,1,0,0,3'b001,3'b111,0,1);
        add(0,1,0,0,3'b001,3'b111,0,0); add(0,1,0,0,3'b001,3'b111,0,0); add(1,1,0,0,3'b001,3'b111,1,1);
        run_vectors("post_rst");

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            x       = 1'($urandom_range(0, 1));
            x_valid = ($urandom_range(0, 3) != 0);
            clr_cnt = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 31) == 0) begin
                p3 = 3'($urandom); c3 = 3'($urandom);
                p5 = 5'($urandom); c5 = 5'($urandom);
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
